// File: rtl/reflow_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reflow_scoreboard: in-flight writer tracker with operand forwarding/stall  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reflow_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int NUM_RD   = 2,
   parameter int FILL_IDX = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hold,
   input  logic                     flush,
   input  logic                     in_en,
   input  logic [ADDR_W-1:0]        in_req,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_ready,
   input  logic                     fill_en,
   input  logic [DATA_W-1:0]        fill_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_req,
   input  logic [NUM_RD*DATA_W-1:0] rd_origin,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     stall,
   output logic [15:0]              stall_cnt
);

   logic              r_valid [DEPTH];
   logic [ADDR_W-1:0] r_req   [DEPTH];
   logic [DATA_W-1:0] r_data  [DEPTH];
   logic              r_ready [DEPTH];
   logic [15:0]       r_stall_cnt;
   logic [NUM_RD-1:0] w_port_stall;
   logic              w_fill_hit;

   assign w_fill_hit = fill_en && r_valid[FILL_IDX] && !r_ready[FILL_IDX];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_ready[i] <= 1'b0;
         end
         r_stall_cnt <= '0;
      end else begin
         if (stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_valid[i] <= 1'b0;
            end
         end else if (!hold) begin
            r_valid[0] <= in_en && (in_req != '0);
            r_req[0]   <= in_req;
            r_data[0]  <= in_data;
            r_ready[0] <= in_ready;
            for (int i = 1; i < DEPTH; i++) begin
               r_valid[i] <= r_valid[i-1];
               r_req[i]   <= r_req[i-1];
               // a late result lands in the entry as it moves one stage older
               if ((i - 1 == FILL_IDX) && w_fill_hit) begin
                  r_data[i]  <= fill_data;
                  r_ready[i] <= 1'b1;
               end else begin
                  r_data[i]  <= r_data[i-1];
                  r_ready[i] <= r_ready[i-1];
               end
            end
         end else if (w_fill_hit) begin
            r_data[FILL_IDX]  <= fill_data;
            r_ready[FILL_IDX] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_port
      logic [ADDR_W-1:0] w_sel;
      logic              w_hit;
      logic              w_hit_ready;
      logic [DATA_W-1:0] w_hit_data;

      assign w_sel = rd_req[k*ADDR_W +: ADDR_W];

      // oldest-to-youngest scan so the youngest match is the last one kept
      always_comb begin
         w_hit       = 1'b0;
         w_hit_ready = 1'b0;
         w_hit_data  = '0;
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_req[i] == w_sel) && (w_sel != '0)) begin
               w_hit       = 1'b1;
               w_hit_ready = r_ready[i];
               w_hit_data  = r_data[i];
            end
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = (w_hit && w_hit_ready) ? w_hit_data
                                                                   : rd_origin[k*DATA_W +: DATA_W];
      assign w_port_stall[k] = w_hit && !w_hit_ready;
   end

   assign stall     = |w_port_stall;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reflow_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reflow_scoreboard: directed bench with a cycle model of the scoreboard  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reflow_scoreboard;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int DEPTH    = 3;
   localparam int NUM_RD   = 2;
   localparam int FILL_IDX = 1;

   logic                     clk = 1'b0;
   logic                     rst, hold, flush, in_en, in_ready, fill_en;
   logic [ADDR_W-1:0]        in_req;
   logic [DATA_W-1:0]        in_data, fill_data;
   logic [NUM_RD*ADDR_W-1:0] rd_req;
   logic [NUM_RD*DATA_W-1:0] rd_origin;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     stall;
   logic [15:0]              stall_cnt;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   reflow_scoreboard #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .FILL_IDX(FILL_IDX)
   ) dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .in_en(in_en), .in_req(in_req), .in_data(in_data), .in_ready(in_ready),
      .fill_en(fill_en), .fill_data(fill_data),
      .rd_req(rd_req), .rd_origin(rd_origin),
      .rd_data(rd_data), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] req;
      logic [DATA_W-1:0] data;
      logic              rdy;
   } ent_t;
   typedef ent_t [DEPTH-1:0] st_t;

   st_t         m;
   logic [15:0] m_cnt;

   function automatic st_t model_next(st_t s);
      st_t  n = s;
      ent_t e;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) n[i].v = 1'b0;
         return n;
      end
      if (fill_en && n[FILL_IDX].v && !n[FILL_IDX].rdy) begin
         n[FILL_IDX].data = fill_data;
         n[FILL_IDX].rdy  = 1'b1;
      end
      if (!hold) begin
         e.v    = in_en && (in_req != 0);
         e.req  = in_req;
         e.data = in_data;
         e.rdy  = in_ready;
         n = {n[DEPTH-2:0], e};
      end
      return n;
   endfunction

   // returns {stall_term, operand}
   function automatic logic [DATA_W:0] resolve(st_t s, logic [ADDR_W-1:0] r, logic [DATA_W-1:0] o);
      if (r != 0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (s[i].v && s[i].req == r) return s[i].rdy ? {1'b0, s[i].data} : {1'b1, o};
         end
      end
      return {1'b0, o};
   endfunction

   function automatic logic model_stall(st_t s);
      logic st = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [DATA_W:0] res;
         res = resolve(s, rd_req[k*ADDR_W +: ADDR_W], rd_origin[k*DATA_W +: DATA_W]);
         st  = st | res[DATA_W];
      end
      return st;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m     <= '0;
         m_cnt <= 16'd0;
      end else begin
         m <= model_next(m);
         if (model_stall(m) && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NUM_RD; k++) begin
            logic [DATA_W:0] res;
            res = resolve(m, rd_req[k*ADDR_W +: ADDR_W], rd_origin[k*DATA_W +: DATA_W]);
            chk($sformatf("model rd_data[%0d]", k), rd_data[k*DATA_W +: DATA_W], res[DATA_W-1:0]);
         end
         chk("model stall", {31'd0, stall}, {31'd0, model_stall(m)});
         chk("model stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
      end
   end

   localparam logic [DATA_W-1:0] ORG0 = 32'h1000_0001;
   localparam logic [DATA_W-1:0] ORG1 = 32'h2000_0002;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d, input logic rdy);
      in_en = 1'b1; in_req = r; in_data = d; in_ready = rdy;
      tick();
      in_en = 1'b0; in_req = '0; in_data = '0; in_ready = 1'b0;
   endtask

   task automatic set_rd(input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
      rd_req = {r1, r0};
      #1;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; flush = 1'b0; in_en = 1'b0; in_req = '0; in_data = '0;
      in_ready = 1'b0; fill_en = 1'b0; fill_data = '0; rd_req = '0;
      rd_origin = {ORG1, ORG0};
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      set_rd(5'd3, 5'd3);
      chk("reset rd_data0", rd_data[31:0], ORG0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
      set_rd(0, 0);

      // basic forward
      insert(5'd3, 32'h0000_AAAA, 1'b1);
      set_rd(5'd3, 0);
      chk("fwd rd_data0", rd_data[31:0], 32'h0000_AAAA);
      chk("fwd stall", {31'd0, stall}, 32'd0);
      set_rd(0, 0);

      // youngest wins, then ages out
      insert(5'd5, 32'h1, 1'b1);
      insert(5'd5, 32'h2, 1'b1);
      set_rd(5'd5, 5'd3);
      chk("youngest rd_data0", rd_data[31:0], 32'h2);
      chk("oldest rd_data1", rd_data[63:32], 32'h0000_AAAA);
      tick(); tick(); tick();
      chk("aged rd_data0", rd_data[31:0], ORG0);
      chk("aged rd_data1", rd_data[63:32], ORG1);
      set_rd(0, 0);

      // not-ready stall then fill under hold
      insert(5'd7, 32'h0, 1'b0);
      set_rd(5'd7, 0);
      chk("nr stall", {31'd0, stall}, 32'd1);
      chk("nr rd_data0", rd_data[31:0], ORG0);
      tick();
      chk("nr stall_cnt", {16'd0, stall_cnt}, 32'd1);
      hold = 1'b1; fill_en = 1'b1; fill_data = 32'h55;
      tick();
      fill_en = 1'b0;
      #1;
      chk("fill rd_data0", rd_data[31:0], 32'h55);
      chk("fill stall", {31'd0, stall}, 32'd0);
      chk("fill stall_cnt", {16'd0, stall_cnt}, 32'd2);
      hold = 1'b0;
      set_rd(0, 0);

      // fill while shifting lands one stage older
      insert(5'd9, 32'h0, 1'b0);
      tick();
      fill_en = 1'b1; fill_data = 32'h66;
      tick();
      fill_en = 1'b0;
      set_rd(5'd9, 5'd9);
      chk("shift fill rd_data1", rd_data[63:32], 32'h66);
      set_rd(0, 0);

      // ready younger shadows not-ready older
      insert(5'd4, 32'h0, 1'b0);
      insert(5'd4, 32'h44, 1'b1);
      set_rd(5'd4, 0);
      chk("shadow rd_data0", rd_data[31:0], 32'h44);
      chk("shadow stall", {31'd0, stall}, 32'd0);
      set_rd(0, 0);

      // index 0 never forwards
      insert(5'd0, 32'hFFFF, 1'b1);
      set_rd(0, 0);
      chk("zero rd_data0", rd_data[31:0], ORG0);
      chk("zero rd_data1", rd_data[63:32], ORG1);

      // flush keeps counter, reset clears it
      insert(5'd12, 32'h0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      set_rd(5'd12, 0);
      chk("flush stall", {31'd0, stall}, 32'd0);
      chk("flush rd_data0", rd_data[31:0], ORG0);
      chk("flush stall_cnt", {16'd0, stall_cnt}, 32'd2);
      insert(5'd12, 32'h0, 1'b0);
      chk("pre-rst stall", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst stall", {31'd0, stall}, 32'd0);
      chk("rst rd_data0", rd_data[31:0], ORG0);
      set_rd(0, 0);

      // saturation
      insert(5'd7, 32'h0, 1'b0);
      hold = 1'b1;
      set_rd(5'd7, 0);
      for (int i = 0; i < 70000; i++) tick();
      chk("sat stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
      chk("sat stall", {31'd0, stall}, 32'd1);
      hold = 1'b0;
      set_rd(0, 0);
      tick(); tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
